// File: rtl/uart_pkg.sv
// Shared UART transmitter types: FSM state encodings, data width and a counter-width helper.
package uart_pkg;

    localparam int DATA_W = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } tx_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO, DEPTH entries; a write is counted at its edge, read data is the stored head while not empty.
// Writes while full are dropped (no rescue by a same-cycle read); reads while empty are ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      i_Clock,
    input  logic                      i_Rst_L,
    input  logic                      i_Wr,
    input  logic [DATA_W-1:0]         i_Wr_Data,
    input  logic                      i_Rd,
    output logic                      o_Full,
    output logic                      o_Empty,
    output logic [$clog2(DEPTH):0]    o_Count,
    output logic [DATA_W-1:0]         o_Rd_Data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, rd_en;

    assign o_Full    = (count_q == FULL_CNT);
    assign o_Empty   = (count_q == '0);
    assign o_Count   = count_q;
    assign o_Rd_Data = mem_q[rd_ptr_q];

    assign wr_en = i_Wr & ~o_Full;
    assign rd_en = i_Rd & ~o_Empty;

    // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_Wr_Data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// FIFO-fed UART transmitter (start, 8 data LSB first, optional parity, stop); start bit leaves one cycle after the byte is counted.
// o_Tx_Ready drops when the FIFO is full; a write then is dropped and flagged on o_Overflow the next cycle.
module uart_tx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int CLK_W = width_of(CLKS_PER_BIT);
    localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    tx_state_e         state_q, state_d;
    logic [CLK_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              serial_q, serial_d;
    logic              active_q;
    logic              done_q, done_d;
    logic              ovf_q;

    logic              fifo_full, fifo_empty, fifo_rd;
    logic [DATA_W-1:0] fifo_dat;
    logic              bit_end;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock   (i_Clock),
        .i_Rst_L   (i_Rst_L),
        .i_Wr      (i_Tx_DV),
        .i_Wr_Data (i_Tx_Byte),
        .i_Rd      (fifo_rd),
        .o_Full    (fifo_full),
        .o_Empty   (fifo_empty),
        .o_Count   (o_Fifo_Count),
        .o_Rd_Data (fifo_dat)
    );

    assign bit_end = (clk_cnt_q == CLK_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        fifo_rd   = 1'b0;

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    // Byte and its parity are captured here so later writes cannot disturb the frame.
                    fifo_rd   = 1'b1;
                    shift_d   = fifo_dat;
                    parity_d  = (^fifo_dat) ^ PAR_ODD;
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so the serial output is a plain flop.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            PARITY:  serial_d = parity_d;
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            serial_q  <= 1'b1;
            active_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            serial_q  <= serial_d;
            active_q  <= (state_d != IDLE);
            done_q    <= done_d;
            ovf_q     <= i_Tx_DV & fifo_full;
        end
    end

    assign o_Tx_Ready  = ~fifo_full;
    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = active_q;
    assign o_Tx_Done   = done_q;
    assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl at CLKS_PER_BIT=4, FIFO_DEPTH=4, with a behavioural 8N1 receiver on the line.
module tb_uart_tx_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] byte_in;
    logic       dv0, dv_pe, dv_po;

    logic       rdy0, ser0, act0, done0, ovf0;
    logic [2:0] cnt0;
    logic       rdy_pe, ser_pe, act_pe, done_pe, ovf_pe;
    logic [2:0] cnt_pe;
    logic       rdy_po, ser_po, act_po, done_po, ovf_po;
    logic [2:0] cnt_po;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv0), .i_Tx_Byte(byte_in),
        .o_Tx_Ready(rdy0), .o_Tx_Serial(ser0), .o_Tx_Active(act0), .o_Tx_Done(done0),
        .o_Overflow(ovf0), .o_Fifo_Count(cnt0)
    );

    uart_tx_fifo_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv_pe), .i_Tx_Byte(byte_in),
        .o_Tx_Ready(rdy_pe), .o_Tx_Serial(ser_pe), .o_Tx_Active(act_pe), .o_Tx_Done(done_pe),
        .o_Overflow(ovf_pe), .o_Fifo_Count(cnt_pe)
    );

    uart_tx_fifo_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
        .i_Clock(clk), .i_Rst_L(rst_n), .i_Tx_DV(dv_po), .i_Tx_Byte(byte_in),
        .o_Tx_Ready(rdy_po), .o_Tx_Serial(ser_po), .o_Tx_Active(act_po), .o_Tx_Done(done_po),
        .o_Overflow(ovf_po), .o_Fifo_Count(cnt_po)
    );

    // Monitors, sampled on the falling edge away from the active edge.
    int         done_cnt = 0;
    int         ovf_cnt  = 0;
    int         done_cyc[$];
    logic [7:0] rx_q[$];
    int         frm_err  = 0;
    logic       rx_busy  = 1'b0;
    int         rx_ph    = 0;
    logic [7:0] rx_sh    = 8'h00;

    always @(negedge clk) begin
        if (done0) begin
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
        end
        if (ovf0) ovf_cnt = ovf_cnt + 1;

        if (!rst_n) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (ser0 == 1'b0) begin
                rx_busy = 1'b1;
                rx_ph   = 0;
            end
        end else begin
            rx_ph = rx_ph + 1;
            if (rx_ph == 2 && ser0 != 1'b0) begin
                rx_busy = 1'b0;
            end else if (rx_ph >= 6 && rx_ph <= 34 && ((rx_ph - 6) % 4) == 0) begin
                rx_sh = {ser0, rx_sh[7:1]};
            end else if (rx_ph == 38) begin
                if (ser0) rx_q.push_back(rx_sh);
                else      frm_err = frm_err + 1;
                rx_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int limit);
        int k;
        k = 0;
        while (done_cnt < target && k < limit) begin
            tick();
            k++;
        end
        chk("done_count", done_cnt, target);
    endtask

    // One parity frame; c counts cycles after the write edge.
    task automatic par_frame(input logic odd, input logic [7:0] b, input logic exp_par, input string tag);
        byte_in = b;
        if (odd) dv_po = 1'b1; else dv_pe = 1'b1;
        tick();
        dv_po = 1'b0;
        dv_pe = 1'b0;
        repeat (34) tick();
        chk({tag, "_d7"}, odd ? ser_po : ser_pe, b[7]);
        repeat (4) tick();
        chk({tag, "_par"}, odd ? ser_po : ser_pe, exp_par);
        repeat (4) tick();
        chk({tag, "_stop"}, odd ? ser_po : ser_pe, 1'b1);
        repeat (3) tick();
        chk({tag, "_done"}, odd ? done_po : done_pe, 1'b1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_a5;
        int         act_n;
        int         base;
        logic [7:0] sent[$];
        logic [2:0] ovf_cnt_exp [6];
        logic       ovf_exp [6];
        logic       rdy_exp [6];

        exp_a5 = 10'b1101001010;
        ovf_cnt_exp = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        ovf_exp     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rdy_exp     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0; dv0 = 1'b0; dv_pe = 1'b0; dv_po = 1'b0; byte_in = 8'h00;
        repeat (3) tick();
        chk("rst_serial", ser0, 1'b1);
        chk("rst_ready",  rdy0, 1'b1);
        chk("rst_active", act0, 1'b0);
        chk("rst_done",   done0, 1'b0);
        chk("rst_ovf",    ovf0, 1'b0);
        chk("rst_count",  cnt0, 3'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte 0xA5, cycle-exact line check.
        base = done_cnt;
        byte_in = 8'hA5; dv0 = 1'b1;
        tick();
        dv0 = 1'b0;
        chk("a5_count", cnt0, 3'd1);
        act_n = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            chk($sformatf("a5_line_c%0d", c), ser0, exp_a5[(c - 1) / 4]);
            if (act0) act_n++;
        end
        tick();
        chk("a5_done",       done0, 1'b1);
        chk("a5_active_off", act0, 1'b0);
        chk("a5_active_len", act_n, 40);
        tick();
        chk("a5_done_pulse", done0, 1'b0);
        repeat (10) tick();
        chk("a5_done_once", done_cnt - base, 1);
        chk("a5_rx_size", rx_q.size(), 1);
        if (rx_q.size() > 0) chk("a5_rx_byte", rx_q[0], 8'hA5);

        // Parity: even A5 -> 0, even 07 -> 1, odd 07 -> 0.
        par_frame(1'b0, 8'hA5, 1'b0, "pe_a5");
        par_frame(1'b0, 8'h07, 1'b1, "pe_07");
        par_frame(1'b1, 8'h07, 1'b0, "po_07");

        // Burst of five on consecutive cycles.
        rx_q.delete();
        base = done_cnt;
        for (int i = 0; i < 5; i++) begin
            byte_in = 8'h11 * (i + 1); dv0 = 1'b1;
            tick();
            chk($sformatf("burst_ovf%0d", i), ovf0, 1'b0);
        end
        dv0 = 1'b0;
        chk("burst_count", cnt0, 3'd4);
        wait_done(base + 5, 300);
        chk("burst_rx_size", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk($sformatf("burst_rx%0d", i), rx_q[i], 8'h11 * (i + 1));
        for (int i = 1; i < 5 && base + i < done_cyc.size(); i++)
            chk($sformatf("burst_gap%0d", i), done_cyc[base + i] - done_cyc[base + i - 1], 41);
        repeat (5) tick();

        // Overflow: six writes while the FSM is busy with the first.
        rx_q.delete();
        base = done_cnt;
        for (int w = 0; w < 6; w++) begin
            byte_in = 8'h61 + 8'(w); dv0 = 1'b1;
            tick();
            chk($sformatf("ovf_count%0d", w), cnt0, ovf_cnt_exp[w]);
            chk($sformatf("ovf_ready%0d", w), rdy0, rdy_exp[w]);
            chk($sformatf("ovf_pulse%0d", w), ovf0, ovf_exp[w]);
        end
        dv0 = 1'b0;
        tick();
        chk("ovf_pulse_end", ovf0, 1'b0);
        wait_done(base + 5, 400);
        repeat (100) tick();
        chk("ovf_frames", done_cnt - base, 5);
        chk("ovf_rx_size", rx_q.size(), 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++)
            chk($sformatf("ovf_rx%0d", i), rx_q[i], 8'h61 + 8'(i));

        // Reset during data bit 3 with two bytes queued.
        rx_q.delete();
        byte_in = 8'hA5; dv0 = 1'b1;
        tick();
        byte_in = 8'hB6;
        tick();
        byte_in = 8'hC7;
        tick();
        dv0 = 1'b0;
        repeat (16) tick();
        chk("mid_d3_line", ser0, 1'b0);
        chk("mid_queued",  cnt0, 3'd2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_line",   ser0, 1'b1);
        chk("mid_rst_count",  cnt0, 3'd0);
        chk("mid_rst_active", act0, 1'b0);
        repeat (3) tick();
        rst_n = 1'b1;
        base = done_cnt;
        repeat (100) tick();
        chk("mid_post_done",  done_cnt - base, 0);
        chk("mid_post_rx",    rx_q.size(), 0);
        chk("mid_post_count", cnt0, 3'd0);
        chk("mid_post_line",  ser0, 1'b1);

        // Loopback of 256 random bytes through the receiver model.
        rx_q.delete();
        base = done_cnt;
        act_n = ovf_cnt;
        for (int i = 0; i < 256; i++) begin
            int k;
            logic [7:0] b;
            b = 8'($urandom_range(0, 255));
            k = 0;
            while (!rdy0 && k < 100) begin
                tick();
                k++;
            end
            byte_in = b; dv0 = 1'b1;
            sent.push_back(b);
            tick();
            dv0 = 1'b0;
        end
        wait_done(base + 256, 256 * 41 + 200);
        repeat (5) tick();
        chk("loop_rx_size", rx_q.size(), 256);
        chk("loop_rx_vs_done", rx_q.size(), done_cnt - base);
        chk("loop_ovf", ovf_cnt - act_n, 0);
        chk("loop_frm_err", frm_err, 0);
        for (int i = 0; i < 256 && i < rx_q.size(); i++)
            chk($sformatf("loop_rx%0d", i), rx_q[i], sent[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- UART transmitter: serialises bytes as 1 start bit, 8 data bits (LSB first), optional parity bit, 1 stop bit.
- A small input FIFO decouples producers, such as the PUF response readout logic, from the serial line rate.
- Pairs with the existing 8N1 UART receiver; both blocks are configured with the same CLKS_PER_BIT.
- The line idles high.

Parameters:
- CLKS_PER_BIT, 87: clocks per serial bit, equal to (i_Clock frequency)/(baud rate); must be >= 2.
- FIFO_DEPTH, 4: number of byte entries; must be a power of 2 and >= 2.
- PARITY_EN, 0: 1 inserts a parity bit between bit 7 and the stop bit.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.

Ports:
- i_Clock, in, 1: single clock.
- i_Rst_L, in, 1: asynchronous, active-low reset.
- i_Tx_DV, in, 1: write strobe, one byte per cycle high.
- i_Tx_Byte, in, 8: byte to send; sampled when i_Tx_DV=1.
- o_Tx_Ready, out, 1: FIFO not full.
- o_Tx_Serial, out, 1: serial line.
- o_Tx_Active, out, 1: a frame is in progress.
- o_Tx_Done, out, 1: one-cycle pulse after a stop bit completes.
- o_Overflow, out, 1: one-cycle pulse when a write is dropped.
- o_Fifo_Count, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, while i_Rst_L=0):
  - o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Fifo_Count=0.
  - FIFO pointers cleared, state=IDLE, bit counter and clock counter cleared.
- Reset mid-frame: the line returns high immediately and the partial frame and all queued bytes are discarded.
- Outputs: all are registered, no combinational path from inputs.
- FIFO write:
  - Accepted at a clock edge when i_Tx_DV=1 and the registered o_Tx_Ready=1.
  - When i_Tx_DV=1 and the FIFO is full, the byte is dropped and o_Overflow is high the next cycle.
  - A pop in that same cycle does not rescue the write.
- Simultaneous write and pop when not full: both occur, count unchanged.
- Pointers wrap modulo FIFO_DEPTH. The count is one bit wider than the pointers, so full and empty are distinguished.
- State machine (clock counter width $clog2(CLKS_PER_BIT)):
  - IDLE:
    - o_Tx_Serial=1, o_Tx_Active=0.
    - If the FIFO is not empty: pop the head into the shift register, clear the counters, go to START.
  - START:
    - o_Tx_Serial=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
  - DATA:
    - o_Tx_Serial = shift register bit 0, each bit held for CLKS_PER_BIT cycles, then shift right.
    - After 8 bits go to PARITY if PARITY_EN=1, else STOP.
  - PARITY:
    - o_Tx_Serial = XOR of the 8 data bits, XOR PARITY_ODD; held for CLKS_PER_BIT cycles, then go to STOP.
  - STOP:
    - o_Tx_Serial=1 for CLKS_PER_BIT cycles, then go to IDLE and assert o_Tx_Done for exactly one cycle.
- o_Tx_Active is 1 in START, DATA, PARITY and STOP.
- Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE is counted at N, popped at N+1, and drives the start bit from N+1.
- Back-to-back frames: one IDLE cycle follows each STOP, so the effective stop bit is CLKS_PER_BIT+1 cycles. The receiver tolerates this.
- Frame length:
  - 10*CLKS_PER_BIT + 1 cycles with PARITY_EN=0.
  - 11*CLKS_PER_BIT + 1 cycles with PARITY_EN=1.
- The data byte is latched at pop time, so later FIFO writes never disturb the frame in flight.

Decomposition:
- Shared package (uart_pkg):
  - State encodings: IDLE, START, DATA, PARITY, STOP as 3-bit localparams.
  - Data width constant 8.
  - A $clog2-based width helper.
- Sub-module uart_tx_fifo:
  - Parameter DEPTH.
  - Ports: write, read, full, empty, count, data.
  - Read data is the registered head, valid while not empty.
- Top level: the FSM, counters, shift register and parity generator.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: write 0xA5, PARITY_EN=0.
  - Line after start: 0,1,0,1,0,0,1,0,1,1, each value 4 cycles.
  - o_Tx_Done pulses once 41 cycles after the write.
  - o_Tx_Active is high for 40 cycles.
- Parity: PARITY_EN=1, PARITY_ODD=0, write 0xA5.
  - Parity bit=0.
  - With PARITY_ODD=1 and byte 0x07, parity bit=0.
  - With PARITY_ODD=0 and byte 0x07, parity bit=1.
- Burst: write 0x11,0x22,0x33,0x44,0x55 on consecutive cycles.
  - The first byte is popped immediately, so 0x55 is accepted.
  - o_Overflow stays 0.
  - Five frames are sent in order, each separated by exactly 1 idle-high cycle beyond the stop bit.
- Overflow: hold the FSM busy and write 6 bytes.
  - o_Tx_Ready=0 once o_Fifo_Count=4.
  - The 6th write causes a one-cycle o_Overflow pulse and that byte is never transmitted.
- Reset mid-frame: assert i_Rst_L=0 during data bit 3 with 2 bytes queued.
  - o_Tx_Serial=1 asynchronously.
  - After release: count=0 and no frames are sent.
- Loopback: connect o_Tx_Serial to the existing receiver with the same CLKS_PER_BIT.
  - Send 256 random bytes.
  - Every byte received equals the byte sent, with one receiver valid pulse per o_Tx_Done.
